// File: rtl/playback_mem.sv
// rtl/playback_mem.sv - bus-loaded waveform buffer with one-shot/looped playback
// Sits on the daisy-chained register bus; all bus traffic passes through with two cycles of delay.
module playback_mem #(
  parameter int BASE_ADDR    = 0,
  parameter int SAMPLE_DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trigger,
  output logic [15:0] dout,
  output logic        dout_valid,
  output logic        running,
  input  logic [15:0] addr_i,
  input  logic [15:0] wdata_i,
  input  logic [15:0] rdata_i,
  input  logic        rw_i,
  input  logic        valid_i,
  output logic [15:0] addr_o,
  output logic [15:0] wdata_o,
  output logic [15:0] rdata_o,
  output logic        rw_o,
  output logic        valid_o
);
  localparam int AW = $clog2(SAMPLE_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {S_IDLE, S_PLAY} state_t;
  state_t r_state, w_state_nxt;

  logic [15:0] r_mem [SAMPLE_DEPTH];
  logic [15:0] r_a_q, r_b_q;

  logic [15:0] r_length;
  logic        r_loop, r_armed, r_done;
  logic [LW-1:0] r_len;
  logic [AW-1:0] r_idx, r_idx1, r_pos;
  logic        r_issuing, r_v1;
  logic [15:0] r_dout;
  logic        r_dout_valid;

  logic [15:0] r_addr1, r_wdata1, r_rdata1, r_rd_reg1;
  logic        r_rw1, r_valid1, r_rd_hit1, r_rd_buf1;

  logic [15:0] w_off, w_reg_rd;
  logic [AW-1:0] w_a_addr;
  logic        w_own, w_is_buf, w_wr, w_rd;
  logic        w_ctrl_wr, w_len_wr, w_buf_wr;
  logic        w_stop, w_start_cmd, w_arm, w_trig_start, w_commit;
  logic        w_last_issue, w_finish, w_len_nz;

  assign w_off    = addr_i - 16'(BASE_ADDR);
  assign w_own    = 32'(w_off) < 32'(SAMPLE_DEPTH + 4);
  assign w_is_buf = (w_off[15:2] != 14'd0);
  assign w_a_addr = AW'(w_off - 16'd4);
  assign w_wr     = valid_i & rw_i & w_own;
  assign w_rd     = valid_i & ~rw_i & w_own;

  assign w_ctrl_wr = w_wr & (w_off == 16'd0);
  assign w_len_wr  = w_wr & (w_off == 16'd1);
  assign w_buf_wr  = w_wr & w_is_buf;
  assign w_len_nz  = (r_length != 16'd0);

  // STOP wins over everything written alongside it
  assign w_stop       = w_ctrl_wr & wdata_i[1];
  assign w_start_cmd  = w_ctrl_wr & wdata_i[0] & ~wdata_i[1] & w_len_nz;
  assign w_arm        = w_ctrl_wr & wdata_i[2] & ~wdata_i[1] & w_len_nz & (r_state == S_IDLE);
  assign w_trig_start = (r_state == S_IDLE) & r_armed & trigger & w_len_nz;
  assign w_commit     = ~w_stop & (w_start_cmd | w_trig_start);

  assign w_last_issue = r_issuing & ({1'b0, r_idx} == (r_len - 1'b1));
  assign w_finish     = (r_state == S_PLAY) & ~r_issuing & ~r_v1 & ~w_stop & ~w_commit;

  assign running    = (r_state == S_PLAY);
  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;

  always_comb begin
    w_reg_rd = 16'd0;
    case (w_off[1:0])
      2'd0: w_reg_rd = {12'd0, r_loop, r_armed, 1'b0, running};
      2'd1: w_reg_rd = r_length;
      2'd2: w_reg_rd = {13'd0, r_done, r_armed, running};
      default: w_reg_rd = 16'(r_pos);
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_stop)        w_state_nxt = S_IDLE;
    else if (w_commit) w_state_nxt = S_PLAY;
    else if (w_finish) w_state_nxt = S_IDLE;
  end

  // Both ports read-first: a same-cycle write is seen by neither read
  always_ff @(posedge clk) begin
    if (w_buf_wr) r_mem[w_a_addr] <= wdata_i;
    r_a_q <= r_mem[w_a_addr];
    r_b_q <= r_mem[r_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_length     <= 16'd0;
      r_loop       <= 1'b0;
      r_armed      <= 1'b0;
      r_done       <= 1'b0;
      r_len        <= '0;
      r_idx        <= '0;
      r_idx1       <= '0;
      r_pos        <= '0;
      r_issuing    <= 1'b0;
      r_v1         <= 1'b0;
      r_dout       <= 16'd0;
      r_dout_valid <= 1'b0;
      r_addr1      <= 16'd0;
      r_wdata1     <= 16'd0;
      r_rdata1     <= 16'd0;
      r_rd_reg1    <= 16'd0;
      r_rw1        <= 1'b0;
      r_valid1     <= 1'b0;
      r_rd_hit1    <= 1'b0;
      r_rd_buf1    <= 1'b0;
      addr_o       <= 16'd0;
      wdata_o      <= 16'd0;
      rdata_o      <= 16'd0;
      rw_o         <= 1'b0;
      valid_o      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_addr1   <= addr_i;
      r_wdata1  <= wdata_i;
      r_rdata1  <= rdata_i;
      r_rw1     <= rw_i;
      r_valid1  <= valid_i;
      r_rd_hit1 <= w_rd;
      r_rd_buf1 <= w_is_buf;
      r_rd_reg1 <= w_reg_rd;
      addr_o    <= r_addr1;
      wdata_o   <= r_wdata1;
      rw_o      <= r_rw1;
      valid_o   <= r_valid1;
      rdata_o   <= r_rd_hit1 ? (r_rd_buf1 ? r_a_q : r_rd_reg1) : r_rdata1;

      if (w_len_wr)  r_length <= (wdata_i > 16'(SAMPLE_DEPTH)) ? 16'(SAMPLE_DEPTH) : wdata_i;
      if (w_ctrl_wr) r_loop <= wdata_i[3];

      if (w_stop || w_commit)  r_armed <= 1'b0;
      else if (w_arm)          r_armed <= 1'b1;

      if (w_start_cmd || w_arm) r_done <= 1'b0;
      else if (w_finish)        r_done <= 1'b1;

      if (w_stop || w_commit) begin
        r_issuing    <= w_commit;
        r_idx        <= '0;
        r_v1         <= 1'b0;
        r_dout_valid <= 1'b0;
        if (w_commit) r_len <= LW'(r_length);
      end else begin
        r_v1         <= r_issuing;
        r_idx1       <= r_idx;
        r_dout_valid <= r_v1;
        if (r_v1) begin
          r_dout <= r_b_q;
          r_pos  <= r_idx1;
        end
        if (w_last_issue) begin
          r_idx <= '0;
          if (!r_loop) r_issuing <= 1'b0;
        end else if (r_issuing) begin
          r_idx <= r_idx + 1'b1;
        end
      end
    end
  end
endmodule
